r5p_wbu: RTL and testbench

Writeback unit for the r5p core: the sole driver of the general-purpose register file write port (`e_rd`/`a_rd`/`d_rd`). It merges single-cycle execute results with out-of-order-in-time, in-order-returning load responses. It tracks load destinations issued but not yet written, and gives decode a hazard flag so operands are never read from a register with a pending write.

---
 rtl/r5p_pkg.sv | 9 +
 rtl/r5p_wbu_if.sv | 42 ++++
 rtl/r5p_wbu_fifo.sv | 73 +++++++
 rtl/r5p_wbu.sv | 139 +++++++++++++
 tb/tb_r5p_wbu.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/r5p_pkg.sv
// Shared r5p core package: register address type and default widths.
package r5p_pkg;

  localparam int unsigned AW_DEF = 5;   // GPR address width (4 for RV32E)
  localparam int unsigned XW_DEF = 32;  // XLEN

  typedef logic [AW_DEF-1:0] gpr_adr_t;

endpackage : r5p_pkg

// File: rtl/r5p_wbu_if.sv
// Writeback unit bus: execute results, load issue, LSU responses, hazard
// check and register file write port.
//   master: pipeline side (drives execute/load/response/check inputs)
//   slave : r5p_wbu (drives ready, hazard, error and write port)
interface r5p_wbu_if
  import r5p_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned XW = XW_DEF
) ();

  logic          alu_vld;
  logic [AW-1:0] alu_rd;
  logic [XW-1:0] alu_dat;
  logic          ld_req;
  logic [AW-1:0] ld_rd;
  logic          ld_rdy;
  logic          lsu_vld;
  logic [XW-1:0] lsu_dat;
  logic          lsu_rdy;
  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic [AW-1:0] chk_rd;
  logic          hzd;
  logic          err;
  logic          e_rd;
  logic [AW-1:0] a_rd;
  logic [XW-1:0] d_rd;

  modport master (
    output alu_vld, alu_rd, alu_dat, ld_req, ld_rd, lsu_vld, lsu_dat,
           chk_rs1, chk_rs2, chk_rd,
    input  ld_rdy, lsu_rdy, hzd, err, e_rd, a_rd, d_rd
  );

  modport slave (
    input  alu_vld, alu_rd, alu_dat, ld_req, ld_rd, lsu_vld, lsu_dat,
           chk_rs1, chk_rs2, chk_rd,
    output ld_rdy, lsu_rdy, hzd, err, e_rd, a_rd, d_rd
  );

endinterface : r5p_wbu_if

// File: rtl/r5p_wbu_fifo.sv
// Pending-load destination FIFO. Pop is applied before push, so a push and
// a pop on the sole entry leave only the new entry.
//   i_push/i_dat : enqueue a destination (ignored when full)
//   i_pop        : dequeue the head (ignored when empty)
//   o_head       : oldest destination
//   o_rdy/o_empty: state-derived not-full / empty flags
//   o_vld/o_adr  : per-slot valid and address for hazard compare
module r5p_wbu_fifo
  import r5p_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned QD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [AW-1:0]        i_dat,
  input  logic                 i_pop,
  output logic [AW-1:0]        o_head,
  output logic                 o_rdy,
  output logic                 o_empty,
  output logic [QD-1:0]        o_vld,
  output logic [QD-1:0][AW-1:0] o_adr
);

  localparam int unsigned PW = $clog2(QD);
  localparam int unsigned CW = $clog2(QD + 1);

  logic [QD-1:0][AW-1:0] r_mem;
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_rdy   = (r_cnt < CW'(QD));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & o_rdy;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rp];
  assign o_adr   = r_mem;

  // Storage, pointers (wrap naturally since QD is a power of two) and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_dat;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] w_off;
    w_off = '0;
    o_vld = '0;
    for (int i = 0; i < QD; i++) begin
      w_off    = PW'(i) - r_rp;
      o_vld[i] = (CW'(w_off) < r_cnt);
    end
  end

endmodule : r5p_wbu_fifo

// File: rtl/r5p_wbu.sv
// r5p writeback unit: sole driver of the register file write port. Merges
// execute results with in-order load responses, parks a response that loses
// to the ALU in a one-entry hold register, and flags read hazards.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : r5p_wbu_if slave port (see interface for signal list)
module r5p_wbu
  import r5p_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned XW = XW_DEF,
  parameter int unsigned QD = 2
) (
  input  logic       clk,
  input  logic       rst,
  r5p_wbu_if.slave   bus
);

  logic                  w_fifo_rdy;
  logic                  w_empty;
  logic [AW-1:0]         w_head;
  logic [QD-1:0]         w_vld;
  logic [QD-1:0][AW-1:0] w_adr;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_spur;
  logic                  w_wr_v;
  logic [AW-1:0]         w_wr_a;
  logic [XW-1:0]         w_wr_d;
  logic                  w_hld_set;
  logic                  w_hld_clr;
  logic                  w_hzd;

  logic                  r_hld_v;
  logic [AW-1:0]         r_hld_a;
  logic [XW-1:0]         r_hld_d;
  logic                  r_e_rd;
  logic [AW-1:0]         r_a_rd;
  logic [XW-1:0]         r_d_rd;
  logic                  r_err;

  // Response handshake; with no pending load it is accepted and dropped.
  assign w_hs   = bus.lsu_vld & ~r_hld_v;
  assign w_pop  = w_hs & ~w_empty;
  assign w_spur = w_hs & w_empty;

  r5p_wbu_fifo #(
    .AW (AW),
    .QD (QD)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.ld_req),
    .i_dat   (bus.ld_rd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_rdy   (w_fifo_rdy),
    .o_empty (w_empty),
    .o_vld   (w_vld),
    .o_adr   (w_adr)
  );

  // Write arbitration: ALU, then hold register, then live response.
  always_comb begin
    w_wr_v    = 1'b0;
    w_wr_a    = '0;
    w_wr_d    = '0;
    w_hld_set = 1'b0;
    w_hld_clr = 1'b0;
    if (bus.alu_vld) begin
      w_wr_v    = 1'b1;
      w_wr_a    = bus.alu_rd;
      w_wr_d    = bus.alu_dat;
      w_hld_set = w_pop;
    end else if (r_hld_v) begin
      w_wr_v    = 1'b1;
      w_wr_a    = r_hld_a;
      w_wr_d    = r_hld_d;
      w_hld_clr = 1'b1;
    end else if (w_pop) begin
      w_wr_v    = 1'b1;
      w_wr_a    = w_head;
      w_wr_d    = bus.lsu_dat;
    end
  end

  // Write port, hold register and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e_rd  <= 1'b0;
      r_a_rd  <= '0;
      r_d_rd  <= '0;
      r_hld_v <= 1'b0;
      r_hld_a <= '0;
      r_hld_d <= '0;
      r_err   <= 1'b0;
    end else begin
      r_e_rd <= w_wr_v && (w_wr_a != '0);
      if (w_wr_v && (w_wr_a != '0)) begin
        r_a_rd <= w_wr_a;
        r_d_rd <= w_wr_d;
      end
      if (w_hld_set) begin
        r_hld_v <= 1'b1;
        r_hld_a <= w_head;
        r_hld_d <= bus.lsu_dat;
      end else if (w_hld_clr) begin
        r_hld_v <= 1'b0;
      end
      r_err <= r_err | w_spur;
    end
  end

  function automatic logic f_hit(input logic [AW-1:0] c, input logic [AW-1:0] a);
    return (c != '0) && (c == a);
  endfunction

  function automatic logic f_any(input logic [AW-1:0] a);
    return f_hit(bus.chk_rs1, a) | f_hit(bus.chk_rs2, a) | f_hit(bus.chk_rd, a);
  endfunction

  // Hazard: pending FIFO slots, held response, and the write in flight.
  always_comb begin
    w_hzd = 1'b0;
    for (int i = 0; i < QD; i++) begin
      if (w_vld[i] && f_any(w_adr[i])) w_hzd = 1'b1;
    end
    if (r_hld_v && f_any(r_hld_a)) w_hzd = 1'b1;
    if (r_e_rd && f_any(r_a_rd))   w_hzd = 1'b1;
  end

  assign bus.ld_rdy  = w_fifo_rdy;
  assign bus.lsu_rdy = ~r_hld_v;
  assign bus.hzd     = w_hzd;
  assign bus.err     = r_err;
  assign bus.e_rd    = r_e_rd;
  assign bus.a_rd    = r_a_rd;
  assign bus.d_rd    = r_d_rd;

endmodule : r5p_wbu

// File: tb/tb_r5p_wbu.sv
// Testbench for r5p_wbu: directed vector table, reset sequence, and random
// traffic against a queue-based reference model.
module tb_r5p_wbu;
  import r5p_pkg::*;

  localparam int unsigned QD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  r5p_wbu_if #(.AW(AW_DEF), .XW(XW_DEF)) bus ();

  r5p_wbu #(.AW(AW_DEF), .XW(XW_DEF), .QD(QD)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic set_in(input logic av, input gpr_adr_t ard, input logic [31:0] adat,
                        input logic lr, input gpr_adr_t lrd,
                        input logic lv, input logic [31:0] ldat,
                        input gpr_adr_t c1, input gpr_adr_t c2, input gpr_adr_t c3);
    bus.alu_vld = av;  bus.alu_rd = ard;  bus.alu_dat = adat;
    bus.ld_req  = lr;  bus.ld_rd  = lrd;
    bus.lsu_vld = lv;  bus.lsu_dat = ldat;
    bus.chk_rs1 = c1;  bus.chk_rs2 = c2;  bus.chk_rd = c3;
  endtask

  typedef struct {
    logic        av;  gpr_adr_t ard; logic [31:0] adat;
    logic        lr;  gpr_adr_t lrd;
    logic        lv;  logic [31:0] ldat;
    gpr_adr_t    c1;
    logic        x_ldrdy, x_lrdy, x_hzd;
    logic        x_e; gpr_adr_t x_a; logic [31:0] x_d; logic x_err;
  } vec_t;

  function automatic vec_t mk(input logic av, input gpr_adr_t ard, input logic [31:0] adat,
                              input logic lr, input gpr_adr_t lrd,
                              input logic lv, input logic [31:0] ldat, input gpr_adr_t c1,
                              input logic xld, input logic xlr, input logic xhz,
                              input logic xe, input gpr_adr_t xa, input logic [31:0] xd,
                              input logic xerr);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat; v.lr = lr; v.lrd = lrd;
    v.lv = lv; v.ldat = ldat; v.c1 = c1;
    v.x_ldrdy = xld; v.x_lrdy = xlr; v.x_hzd = xhz;
    v.x_e = xe; v.x_a = xa; v.x_d = xd; v.x_err = xerr;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: queue of pending destinations, optional held response.
  int unsigned mq[$];
  bit          mh_v;
  int unsigned mh_a;
  logic [31:0] mh_d;
  bit          me;
  int unsigned ma;
  logic [31:0] md;
  bit          merr;

  task automatic m_reset();
    mq.delete(); mh_v = 0; mh_a = 0; mh_d = 0; me = 0; ma = 0; md = 0; merr = 0;
  endtask

  function automatic bit m_hit1(input int unsigned c);
    if (c == 0) return 0;
    foreach (mq[i]) if (mq[i] == c) return 1;
    if (mh_v && mh_a == c) return 1;
    if (me && ma == c) return 1;
    return 0;
  endfunction

  task automatic m_write(input int unsigned a, input logic [31:0] d);
    if (a != 0) begin me = 1; ma = a; md = d; end
    else me = 0;
  endtask

  task automatic m_step();
    bit          rsp;
    int unsigned ra;
    int          n0;
    rsp = 0; ra = 0; n0 = mq.size();
    if (bus.lsu_vld && !mh_v) begin
      if (n0 == 0) merr = 1;
      else begin rsp = 1; ra = mq.pop_front(); end
    end
    if (bus.ld_req && n0 < int'(QD)) mq.push_back(int'(bus.ld_rd));
    if (bus.alu_vld) begin
      m_write(int'(bus.alu_rd), bus.alu_dat);
      if (rsp) begin mh_v = 1; mh_a = ra; mh_d = bus.lsu_dat; end
    end else if (mh_v) begin
      m_write(mh_a, mh_d);
      mh_v = 0;
    end else if (rsp) begin
      m_write(ra, bus.lsu_dat);
    end else begin
      me = 0;
    end
  endtask

  vec_t vt[29];

  initial begin
    vt[0]  = mk(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0,            1, 1, 0, 1, 5, 32'h1234_5678, 0);
    vt[1]  = mk(1, 0, 32'h55, 0, 0, 0, 0, 5,                   1, 1, 1, 0, 5, 32'h1234_5678, 0);
    vt[2]  = mk(0, 0, 0, 1, 7, 0, 0, 7,                        1, 1, 0, 0, 5, 32'h1234_5678, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 7,                        1, 1, 1, 0, 5, 32'h1234_5678, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 7,                        1, 1, 1, 0, 5, 32'h1234_5678, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 7,            1, 1, 1, 1, 7, 32'hDEAD_BEEF, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 7,                        1, 1, 1, 0, 7, 32'hDEAD_BEEF, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 7,                        1, 1, 0, 0, 7, 32'hDEAD_BEEF, 0);
    vt[8]  = mk(0, 0, 0, 1, 3, 0, 0, 3,                        1, 1, 0, 0, 7, 32'hDEAD_BEEF, 0);
    vt[9]  = mk(1, 4, 32'hB, 0, 0, 1, 32'hA, 3,                1, 1, 1, 1, 4, 32'hB, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 3,                        1, 0, 1, 1, 3, 32'hA, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 3,                        1, 1, 1, 0, 3, 32'hA, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 3,                        1, 1, 0, 0, 3, 32'hA, 0);
    vt[13] = mk(0, 0, 0, 1, 10, 0, 0, 0,                       1, 1, 0, 0, 3, 32'hA, 0);
    vt[14] = mk(0, 0, 0, 1, 11, 0, 0, 10,                      1, 1, 1, 0, 3, 32'hA, 0);
    vt[15] = mk(0, 0, 0, 1, 12, 0, 0, 12,                      0, 1, 0, 0, 3, 32'hA, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 12,                       0, 1, 0, 0, 3, 32'hA, 0);
    vt[17] = mk(0, 0, 0, 1, 13, 1, 32'h100, 13,                0, 1, 0, 1, 10, 32'h100, 0);
    vt[18] = mk(0, 0, 0, 1, 14, 1, 32'h200, 13,                1, 1, 0, 1, 11, 32'h200, 0);
    vt[19] = mk(0, 0, 0, 0, 0, 1, 32'h300, 14,                 1, 1, 1, 1, 14, 32'h300, 0);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0, 14,                       1, 1, 1, 0, 14, 32'h300, 0);
    vt[21] = mk(0, 0, 0, 0, 0, 0, 0, 14,                       1, 1, 0, 0, 14, 32'h300, 0);
    vt[22] = mk(0, 0, 0, 1, 0, 0, 0, 0,                        1, 1, 0, 0, 14, 32'h300, 0);
    vt[23] = mk(0, 0, 0, 1, 9, 0, 0, 0,                        1, 1, 0, 0, 14, 32'h300, 0);
    vt[24] = mk(0, 0, 0, 0, 0, 1, 32'h400, 9,                  0, 1, 1, 0, 14, 32'h300, 0);
    vt[25] = mk(0, 0, 0, 0, 0, 1, 32'h900, 9,                  1, 1, 1, 1, 9, 32'h900, 0);
    vt[26] = mk(0, 0, 0, 0, 0, 0, 0, 9,                        1, 1, 1, 0, 9, 32'h900, 0);
    vt[27] = mk(0, 0, 0, 0, 0, 1, 32'hBAD, 9,                  1, 1, 0, 0, 9, 32'h900, 1);
    vt[28] = mk(0, 0, 0, 0, 0, 0, 0, 0,                        1, 1, 0, 0, 9, 32'h900, 1);

    // Reset state
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    #1;
    check("rst_e_rd",    32'(bus.e_rd),    32'd0);
    check("rst_a_rd",    32'(bus.a_rd),    32'd0);
    check("rst_d_rd",    bus.d_rd,         32'd0);
    check("rst_ld_rdy",  32'(bus.ld_rdy),  32'd1);
    check("rst_lsu_rdy", 32'(bus.lsu_rdy), 32'd1);
    check("rst_err",     32'(bus.err),     32'd0);
    check("rst_hzd",     32'(bus.hzd),     32'd0);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 29; i++) begin
      set_in(vt[i].av, vt[i].ard, vt[i].adat, vt[i].lr, vt[i].lrd,
             vt[i].lv, vt[i].ldat, vt[i].c1, 5'd0, 5'd0);
      #1;
      check($sformatf("v%0d_ld_rdy", i),  32'(bus.ld_rdy),  32'(vt[i].x_ldrdy));
      check($sformatf("v%0d_lsu_rdy", i), 32'(bus.lsu_rdy), 32'(vt[i].x_lrdy));
      check($sformatf("v%0d_hzd", i),     32'(bus.hzd),     32'(vt[i].x_hzd));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_e_rd", i), 32'(bus.e_rd), 32'(vt[i].x_e));
      check($sformatf("v%0d_a_rd", i), 32'(bus.a_rd), 32'(vt[i].x_a));
      check($sformatf("v%0d_d_rd", i), bus.d_rd,      vt[i].x_d);
      check($sformatf("v%0d_err", i),  32'(bus.err),  32'(vt[i].x_err));
      @(negedge clk);
    end

    // Reset with two pending loads: everything discarded, no write after.
    set_in(0, 0, 0, 1, 5'd20, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 1, 5'd21, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21, 5'd0);
    #1;
    check("mid_hzd_pre",    32'(bus.hzd),    32'd1);
    check("mid_ld_rdy_pre", 32'(bus.ld_rdy), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_ld_rdy", 32'(bus.ld_rdy),  32'd1);
    check("mid_hzd",    32'(bus.hzd),     32'd0);
    check("mid_err",    32'(bus.err),     32'd0);
    check("mid_e_rd",   32'(bus.e_rd),    32'd0);
    check("mid_lsu_rdy",32'(bus.lsu_rdy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_e_rd", 32'(bus.e_rd), 32'd0);
      check("post_rst_hzd",  32'(bus.hzd),  32'd0);
      @(negedge clk);
    end
    // A response now has no owner: dropped, flags error.
    set_in(0, 0, 0, 0, 0, 1, 32'hCAFE, 5'd20, 5'd21, 5'd0);
    @(posedge clk); #1;
    check("post_rst_rsp_e_rd", 32'(bus.e_rd), 32'd0);
    check("post_rst_rsp_err",  32'(bus.err),  32'd1);
    @(negedge clk);

    // Random traffic against the reference model
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic lv;
      if (mq.size() != 0) lv = ($urandom_range(0, 99) < 50);
      else                lv = ($urandom_range(0, 199) < 1);
      set_in(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom(),
             ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)),
             lv, $urandom(),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      check("rnd_ld_rdy",  32'(bus.ld_rdy),  32'(mq.size() < int'(QD)));
      check("rnd_lsu_rdy", 32'(bus.lsu_rdy), 32'(!mh_v));
      check("rnd_hzd",     32'(bus.hzd),
            32'(m_hit1(int'(bus.chk_rs1)) | m_hit1(int'(bus.chk_rs2)) | m_hit1(int'(bus.chk_rd))));
      m_step();
      @(posedge clk);
      #1;
      check("rnd_e_rd", 32'(bus.e_rd), 32'(me));
      check("rnd_a_rd", 32'(bus.a_rd), 32'(ma));
      check("rnd_d_rd", bus.d_rd,      md);
      check("rnd_err",  32'(bus.err),  32'(merr));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_r5p_wbu
